// File: rtl/fetch_queue.sv
// Instruction fetch queue between the I-cache data array and decode: circular buffer of {instr, pc}.
// Optional same-cycle bypass into decode when empty: define FETCH_QUEUE_BYPASS_EN.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module fetch_queue #(
    parameter int FETCH_W  = `FETCH_WIDTH,
    parameter int DECODE_W = 2,
    parameter int DEPTH    = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_flush,
    input  logic                             i_fetch_valid,
    input  logic [`PADDR_WIDTH-1:0]          i_fetch_pc,
    input  logic [`INSTR_WIDTH-1:0]          i_fetch_data [0:FETCH_W-1],
    input  logic [$clog2(FETCH_W+1)-1:0]     i_fetch_count,
    output logic                             o_fetch_ready,
    output logic [DECODE_W-1:0]              o_dec_valid,
    output logic [`INSTR_WIDTH-1:0]          o_dec_instr [0:DECODE_W-1],
    output logic [`PADDR_WIDTH-1:0]          o_dec_pc [0:DECODE_W-1],
    input  logic [$clog2(DECODE_W+1)-1:0]    i_dec_count,
    output logic [$clog2(DEPTH+1)-1:0]       o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = `PADDR_WIDTH;
    localparam int IW = `INSTR_WIDTH;

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [IW-1:0] mem_instr [DEPTH];
    logic [AW-1:0] mem_pc    [DEPTH];

    logic          enq, bypass;
    logic [CW-1:0] fetch_n, avail, deq_n, skip, enq_n;

    assign fetch_n       = (CW'(i_fetch_count) > CW'(FETCH_W)) ? CW'(FETCH_W) : CW'(i_fetch_count);
    // Ready looks only at registered occupancy so it never waits on decode.
    assign o_fetch_ready = (CW'(DEPTH) - count) >= CW'(FETCH_W);
    assign enq           = i_fetch_valid && o_fetch_ready && !i_flush;
    assign o_count       = count;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = enq && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    // While bypassing, decode reads the incoming group directly; consumed slots are never stored.
    always_comb begin
        avail = bypass ? fetch_n : count;
        if (avail > CW'(DECODE_W))
            avail = CW'(DECODE_W);
        deq_n = (CW'(i_dec_count) > avail) ? avail : CW'(i_dec_count);
        skip  = bypass ? deq_n : '0;
        enq_n = enq ? (fetch_n - skip) : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (i_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (!bypass)
                head <= head + PW'(deq_n);
            tail  <= tail + PW'(enq_n);
            count <= count + enq_n - (bypass ? '0 : deq_n);
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < FETCH_W; k++) begin
            if (enq && (CW'(k) < fetch_n) && (CW'(k) >= skip)) begin
                mem_instr[tail + PW'(k) - PW'(skip)] <= i_fetch_data[k];
                mem_pc[tail + PW'(k) - PW'(skip)]    <= i_fetch_pc + AW'(4*k);
            end
        end
    end

    for (genvar k = 0; k < DECODE_W; k++) begin : g_dec
        logic [PW-1:0] ra;
        assign ra = head + PW'(k);
        if (k < FETCH_W) begin : g_byp
            assign o_dec_valid[k] = bypass ? (fetch_n > CW'(k)) : (count > CW'(k));
            assign o_dec_instr[k] = bypass ? i_fetch_data[k] : mem_instr[ra];
            assign o_dec_pc[k]    = bypass ? (i_fetch_pc + AW'(4*k)) : mem_pc[ra];
        end else begin : g_nobyp
            assign o_dec_valid[k] = !bypass && (count > CW'(k));
            assign o_dec_instr[k] = mem_instr[ra];
            assign o_dec_pc[k]    = mem_pc[ra];
        end
    end

    // Decode must never consume more than it was shown; the RTL clamps regardless.
    a_dec_overrun: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !i_flush |-> (CW'(i_dec_count) <= avail));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: constant vector table, corner sequences, and a
// queue-based reference model run against random traffic.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module tb_fetch_queue;
    localparam int FW = 4, DW = 2, DP = 16;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk, rst_n, flush, fetch_valid, fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_data [0:FW-1];
    logic [2:0]  fetch_count;
    logic [1:0]  dec_valid, dec_count;
    logic [31:0] dec_instr [0:DW-1];
    logic [31:0] dec_pc    [0:DW-1];
    logic [4:0]  count;

    fetch_queue #(.FETCH_W(FW), .DECODE_W(DW), .DEPTH(DP)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_fetch_valid(fetch_valid),
        .i_fetch_pc(fetch_pc), .i_fetch_data(fetch_data), .i_fetch_count(fetch_count),
        .o_fetch_ready(fetch_ready), .o_dec_valid(dec_valid), .o_dec_instr(dec_instr),
        .o_dec_pc(dec_pc), .i_dec_count(dec_count), .o_count(count));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t q[$];

    typedef struct {
        bit fl; bit fv; logic [31:0] pc; int fc; int dc;
        int e_cnt; bit e_rdy; logic [1:0] e_vld; logic [31:0] e_pc0;
    } vec_t;
    vec_t tbl[$];

    int n_err = 0, n_chk = 0;
    bit cur_fl, cur_fv;
    logic [31:0] cur_pc;
    int cur_fc, cur_dc;
    bit seq_on = 1'b0;
    logic [31:0] seq_next;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [31:0] mk(logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit model_bypass();
        return BYP && (q.size() == 0) && cur_fv && !cur_fl;
    endfunction

    task automatic apply(input bit fl, input bit fv, input logic [31:0] pc, input int fc, input int dc);
        cur_fl = fl; cur_fv = fv; cur_pc = pc; cur_fc = fc; cur_dc = dc;
        flush = fl; fetch_valid = fv; fetch_pc = pc;
        fetch_count = 3'(fc); dec_count = 2'(dc);
        for (int k = 0; k < FW; k++) fetch_data[k] = mk(pc + 32'(4*k));
    endtask

    // Compares combinational outputs with the model before the edge.
    task automatic check_model();
        int n;
        logic [31:0] epc, ein;
        bit byp;
        byp = model_bypass();
        n = byp ? imin(cur_fc, DW) : imin(q.size(), DW);
        chk("count", 32'(count), 32'(q.size()));
        chk("ready", 32'(fetch_ready), 32'((DP - q.size()) >= FW));
        chk("valid", 32'(dec_valid), 32'((1 << n) - 1));
        for (int k = 0; k < n; k++) begin
            epc = byp ? cur_pc + 32'(4*k) : q[k].pc;
            ein = byp ? mk(epc) : q[k].instr;
            chk("dec_pc", dec_pc[k], epc);
            chk("dec_instr", dec_instr[k], ein);
        end
        if (seq_on)
            for (int k = 0; k < cur_dc; k++) begin
                chk("wrap_seq", dec_pc[k], seq_next);
                seq_next += 32'd4;
            end
    endtask

    task automatic tick();
        int vis;
        vis = model_bypass() ? imin(cur_fc, DW) : imin(q.size(), DW);
        @(posedge clk); #1;
        if (cur_fl) q.delete();
        else begin
            if (cur_fv && (DP - q.size()) >= FW)
                for (int k = 0; k < cur_fc; k++) begin
                    ent_t e;
                    e.pc = cur_pc + 32'(4*k);
                    e.instr = mk(e.pc);
                    q.push_back(e);
                end
            for (int k = 0; k < imin(cur_dc, vis); k++) void'(q.pop_front());
        end
    endtask

    task automatic cycle(input bit fl, input bit fv, input logic [31:0] pc, input int fc, input int dc);
        apply(fl, fv, pc, fc, dc);
        #4;
        check_model();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        apply(0, 0, 32'h0, 0, 0);
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(dec_valid), 32'd0);
        chk("rst_ready", 32'(fetch_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // fill, full, stalled 5th group, drain, simultaneous flush, partial group
        tbl.push_back('{0, 1, 32'h1000, 4, 0,  4, 1, 2'b11, 32'h1000});
        tbl.push_back('{0, 1, 32'h1010, 4, 0,  8, 1, 2'b11, 32'h1000});
        tbl.push_back('{0, 1, 32'h1020, 4, 0, 12, 1, 2'b11, 32'h1000});
        tbl.push_back('{0, 1, 32'h1030, 4, 0, 16, 0, 2'b11, 32'h1000});
        tbl.push_back('{0, 1, 32'h1040, 4, 0, 16, 0, 2'b11, 32'h1000});
        tbl.push_back('{0, 0, 32'h0,    0, 2, 14, 0, 2'b11, 32'h1008});
        tbl.push_back('{0, 0, 32'h0,    0, 2, 12, 1, 2'b11, 32'h1010});
        tbl.push_back('{0, 1, 32'h1040, 4, 2, 14, 0, 2'b11, 32'h1018});
        tbl.push_back('{0, 0, 32'h0,    0, 2, 12, 1, 2'b11, 32'h1020});
        tbl.push_back('{0, 0, 32'h0,    0, 2, 10, 1, 2'b11, 32'h1028});
        tbl.push_back('{0, 0, 32'h0,    0, 2,  8, 1, 2'b11, 32'h1030});
        tbl.push_back('{0, 0, 32'h0,    0, 2,  6, 1, 2'b11, 32'h1038});
        tbl.push_back('{1, 1, 32'h5000, 4, 2,  0, 1, 2'b00, 32'h0});
        tbl.push_back('{0, 1, 32'h2000, 3, 0,  3, 1, 2'b11, 32'h2000});
        tbl.push_back('{0, 0, 32'h0,    0, 2,  1, 1, 2'b01, 32'h2008});
        tbl.push_back('{0, 0, 32'h0,    0, 1,  0, 1, 2'b00, 32'h0});
        foreach (tbl[i]) begin
            cycle(tbl[i].fl, tbl[i].fv, tbl[i].pc, tbl[i].fc, tbl[i].dc);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_ready", i), 32'(fetch_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_valid", i), 32'(dec_valid), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld[0]) chk($sformatf("vec%0d_pc0", i), dec_pc[0], tbl[i].e_pc0);
            if (tbl[i].e_vld[1]) chk($sformatf("vec%0d_pc1", i), dec_pc[1], tbl[i].e_pc0 + 32'd4);
        end

        // Wrap-around: start full, then stream through several pointer wraps.
        for (int g = 0; g < 4; g++) cycle(0, 1, 32'h8000 + 32'(16*g), 4, 0);
        chk("wrap_full", 32'(count), 32'd16);
        begin
            logic [31:0] enq_pc;
            bit fv;
            enq_pc = 32'h8040;
            seq_next = 32'h8000;
            seq_on = 1'b1;
            for (int c = 0; c < 40; c++) begin
                fv = (q.size() <= DP - FW);
                cycle(0, fv, enq_pc, 4, 2);
                if (fv) enq_pc += 32'd16;
            end
            seq_on = 1'b0;
        end
        chk("wrap_count", 32'(count), 32'd12);
        cycle(1, 0, 32'h0, 0, 0);

`ifdef FETCH_QUEUE_BYPASS_EN
        apply(0, 1, 32'h3000, 4, 2);
        #4;
        check_model();
        chk("byp_valid", 32'(dec_valid), 32'h3);
        chk("byp_pc0", dec_pc[0], 32'h3000);
        chk("byp_pc1", dec_pc[1], 32'h3004);
        tick();
        chk("byp_count", 32'(count), 32'd2);
        chk("byp_next_pc0", dec_pc[0], 32'h3008);
        cycle(1, 0, 32'h0, 0, 0);
`endif

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            bit fl, fv, byp;
            int fc, dc, vis;
            logic [31:0] pc;
            fl = ($urandom_range(0, 24) == 0);
            fv = ($urandom_range(0, 3) != 0);
            fc = $urandom_range(0, FW);
            pc = $urandom & 32'hFFFF_FFFC;
            byp = BYP && (q.size() == 0) && fv && !fl;
            vis = byp ? imin(fc, DW) : imin(q.size(), DW);
            dc = fl ? $urandom_range(0, DW) : $urandom_range(0, vis);
            cycle(fl, fv, pc, fc, dc);
        end

        // Reset in the middle of a cycle with data queued.
        cycle(0, 1, 32'h4000, 4, 0);
        cycle(0, 1, 32'h4010, 4, 0);
        apply(0, 0, 32'h0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_valid", 32'(dec_valid), 32'd0);
        chk("midrst_ready", 32'(fetch_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        q.delete();
        @(posedge clk); #1;
        cycle(0, 1, 32'h6000, 2, 0);
        chk("post_rst_count", 32'(count), 32'd2);
        chk("post_rst_pc0", dec_pc[0], 32'h6000);
        cycle(0, 0, 32'h0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
